// File: rtl/wb_arbiter3.sv
// wb_arbiter3: three-master, one-slave 16-bit Wishbone arbiter.
// m0 has priority with anti-starvation; m1/m2 round-robin; bus watchdog.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   mN_adr/dat/sel/we/cyc/stb master N request side (N = 0..2)
//   mN_ack_o/err_o/dat_o      response routed to master N
//   s_adr/dat/sel/we/cyc/stb  slave request side
//   s_ack_i, s_dat_i          slave response
//   grant_o                   one-hot owner, 000 when idle
module wb_arbiter3 #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:1] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [15:0] m0_dat_o,
  input  logic [63:1] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [15:0] m1_dat_o,
  input  logic [63:1] m2_adr_i,
  input  logic [15:0] m2_dat_i,
  input  logic [1:0]  m2_sel_i,
  input  logic        m2_we_i,
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic [15:0] m2_dat_o,
  output logic [63:1] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic [15:0] s_dat_i,
  output logic [2:0]  grant_o
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [2:0] grant_q;
  logic       rr_q;
  logic       m0_last_q;
  logic [7:0] wd_q;
  logic [2:0] req;
  logic [2:0] win;
  logic       own_cyc;
  logic       wd_fire;

  assign req     = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign own_cyc = |(grant_q & req);
  assign grant_o = grant_q;

  // rr_q: 0 favours m1, 1 favours m2
  always_comb begin
    win = 3'b000;
    if (req[0] && !(m0_last_q && (req[1] || req[2])))
      win = 3'b001;
    else if (!rr_q)
      win = req[1] ? 3'b010 : (req[2] ? 3'b100 : 3'b000);
    else
      win = req[2] ? 3'b100 : (req[1] ? 3'b010 : 3'b000);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      grant_q   <= 3'b000;
      rr_q      <= 1'b0;
      m0_last_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|win) begin
            state     <= OWN;
            grant_q   <= win;
            m0_last_q <= win[0];
            if (win[1]) rr_q <= 1'b1;
            if (win[2]) rr_q <= 1'b0;
          end
        end
        OWN: begin
          if (!own_cyc) begin
            state   <= IDLE;
            grant_q <= 3'b000;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 3'b000;
        end
      endcase
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    unique case (1'b1)
      grant_q[0]: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_cyc_i & m0_stb_i;
      end
      grant_q[1]: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_cyc_i & m1_stb_i;
      end
      grant_q[2]: begin
        s_adr_o = m2_adr_i;
        s_dat_o = m2_dat_i;
        s_sel_o = m2_sel_i;
        s_we_o  = m2_we_i;
        s_cyc_o = m2_cyc_i;
        s_stb_o = m2_cyc_i & m2_stb_i;
      end
      default: ;
    endcase
  end

  // Fires in the TIMEOUT-th consecutive unacked strobe cycle
  assign wd_fire = s_stb_o & ~s_ack_i & (wd_q == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i || state == IDLE || !s_stb_o || s_ack_i || wd_fire)
      wd_q <= 8'd0;
    else
      wd_q <= wd_q + 8'd1;
  end

  assign m0_ack_o = grant_q[0] & s_ack_i;
  assign m1_ack_o = grant_q[1] & s_ack_i;
  assign m2_ack_o = grant_q[2] & s_ack_i;
  assign m0_err_o = grant_q[0] & wd_fire;
  assign m1_err_o = grant_q[1] & wd_fire;
  assign m2_err_o = grant_q[2] & wd_fire;
  assign m0_dat_o = grant_q[0] ? s_dat_i : 16'h0000;
  assign m1_dat_o = grant_q[1] ? s_dat_i : 16'h0000;
  assign m2_dat_o = grant_q[2] ? s_dat_i : 16'h0000;

endmodule
